sdram_port_arbiter: RTL

- Shares the board's single SDRAM controller port between three requesters of the HT1080Z core on Poseidon:
  - the data_io ROM/cassette download writer;
  - the video fetch unit;
  - the Z80 CPU bus.
- Sits between the guest core and the SDRAM controller, one access in flight at a time.
- Provides fixed priority with a CPU anti-starvation guard and a watchdog on stalled transactions.

---
 rtl/sdram_port_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the single SDRAM controller port between the download writer, the
// video fetch unit and the Z80 CPU bus. One access is in flight at a time.
// Download has absolute priority. Video beats the CPU, but only until
// VID_BURST_MAX video grants have gone by while the CPU waits; the CPU is then
// forced through. A watchdog aborts any access that the controller never
// acknowledges, returning all-ones read data and latching a sticky error.
module sdram_port_arbiter #(
  parameter int ADDR_W        = 24,
  parameter int VID_BURST_MAX = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,

  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [15:0]       dl_din,
  output logic              dl_ack,

  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [15:0]       vid_dout,
  output logic              vid_ack,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  input  logic [1:0]        cpu_ds,
  output logic [15:0]       cpu_dout,
  output logic              cpu_ack,

  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [15:0]       sd_din,
  output logic [1:0]        sd_ds,
  input  logic [15:0]       sd_dout,
  input  logic              sd_ack,

  output logic [1:0]        owner,
  output logic              timeout_err
);

  localparam int STREAK_W = (VID_BURST_MAX < 1) ? 1 : $clog2(VID_BURST_MAX + 1);
  localparam int WDOG_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VID_BURST_MAX);
  localparam logic [WDOG_W-1:0]   WDOG_LIMIT = WDOG_W'(TIMEOUT);

  // Grant codes, also the encoding presented on the owner port.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DL   = 2'd1;
  localparam logic [1:0] OWN_VID  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  // Read data returned to a requester whose access was aborted.
  localparam logic [15:0] ABORT_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] vid_streak;
  logic [WDOG_W-1:0]   wdog;

  logic [1:0]          winner;
  logic                cpu_forced;
  logic                grant;
  logic                wdog_expired;
  logic                complete;
  logic [15:0]         rd_data;

  // Fixed-priority pick: download, then a starved CPU, then video, then CPU.
  function automatic logic [1:0] pick_winner(input logic dl,
                                              input logic vid,
                                              input logic cpu,
                                              input logic forced);
    logic [1:0] w;
    w = OWN_NONE;
    if (dl)
      w = OWN_DL;
    else if (cpu && forced)
      w = OWN_CPU;
    else if (vid)
      w = OWN_VID;
    else if (cpu)
      w = OWN_CPU;
    return w;
  endfunction

  // Consecutive video wins counted only while the CPU keeps waiting; any
  // cycle without a CPU request, or a CPU grant, starts the count afresh.
  function automatic logic [STREAK_W-1:0] streak_next(input logic [STREAK_W-1:0] cur,
                                                      input logic                cpu,
                                                      input logic                granted,
                                                      input logic [1:0]          who);
    logic [STREAK_W-1:0] nxt;
    nxt = cur;
    if (!cpu)
      nxt = '0;
    else if (granted && (who == OWN_CPU))
      nxt = '0;
    else if (granted && (who == OWN_VID) && (cur != STREAK_MAX))
      nxt = cur + STREAK_W'(1);
    return nxt;
  endfunction

  // Arbitration decision, only acted on while idle.
  always_comb begin
    cpu_forced = cpu_req && (vid_streak == STREAK_MAX);
    winner     = pick_winner(dl_req, vid_req, cpu_req, cpu_forced);
    grant      = (state == ST_IDLE) && (winner != OWN_NONE);
  end

  // Completion of the access in flight: a real ack, or the watchdog giving up.
  always_comb begin
    wdog_expired = (wdog == WDOG_LIMIT);
    complete     = (state == ST_BUSY) && (sd_ack || wdog_expired);
    rd_data      = sd_ack ? sd_dout : ABORT_DATA;
  end

  // Video streak tracking for the CPU anti-starvation guard.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      vid_streak <= '0;
    else
      vid_streak <= streak_next(vid_streak, cpu_req, grant, winner);
  end

  // Access sequencer: grant in IDLE, hold the controller request in BUSY,
  // one dead DONE cycle so a requester can drop its request after the ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wdog        <= '0;
      owner       <= OWN_NONE;
      sd_req      <= 1'b0;
      sd_we       <= 1'b0;
      sd_addr     <= '0;
      sd_din      <= '0;
      sd_ds       <= '0;
      dl_ack      <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_dout    <= '0;
      cpu_dout    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner  <= winner;
            sd_req <= 1'b1;
            wdog   <= '0;
            state  <= ST_BUSY;
            case (winner)
              OWN_DL: begin
                sd_we   <= 1'b1;
                sd_addr <= dl_addr;
                sd_din  <= dl_din;
                sd_ds   <= 2'b11;
              end
              OWN_VID: begin
                sd_we   <= 1'b0;
                sd_addr <= vid_addr;
                sd_din  <= '0;
                sd_ds   <= 2'b11;
              end
              default: begin
                sd_we   <= cpu_we;
                sd_addr <= cpu_addr;
                sd_din  <= cpu_din;
                sd_ds   <= cpu_ds;
              end
            endcase
          end
        end

        ST_BUSY: begin
          if (complete) begin
            sd_req <= 1'b0;
            sd_we  <= 1'b0;
            state  <= ST_DONE;
            if (!sd_ack)
              timeout_err <= 1'b1;
            case (owner)
              OWN_DL: begin
                dl_ack <= 1'b1;
              end
              OWN_VID: begin
                vid_ack  <= 1'b1;
                vid_dout <= rd_data;
              end
              default: begin
                cpu_ack <= 1'b1;
                // sd_we still holds the latched direction of this access here.
                if (!sd_we)
                  cpu_dout <= rd_data;
              end
            endcase
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end

        ST_DONE: begin
          dl_ack  <= 1'b0;
          vid_ack <= 1'b0;
          cpu_ack <= 1'b0;
          owner   <= OWN_NONE;
          state   <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
